// File: rtl/ps2_keyboard_io_if.sv
// CPU I/O bus bundle for the PS/2 keyboard port: read/write strobes, addresses, data and ready flag.
interface ps2_keyboard_io_if;
  logic [15:0] raddr;
  logic [15:0] rdata;
  logic        renable;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        wenable;
  logic        rx_ready;

  modport master (output raddr, renable, waddr, wdata, wenable,
                  input  rdata, rx_ready);
  modport slave  (input  raddr, renable, waddr, wdata, wenable,
                  output rdata, rx_ready);
endinterface

// File: rtl/ps2_keyboard_io.sv
// PS/2 device-to-host receiver with scan-code FIFO, exposed as STATUS/DATA words on the CPU I/O bus.
module ps2_keyboard_io #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF10,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_keyboard_io_if.slave bus
);
  localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronisers reset to 1 so an idle bus never looks like a falling edge
  logic [1:0] clk_sync, dat_sync;
  logic       sclk_prev;
  logic       sclk, sdata, fall;

  assign sclk  = clk_sync[1];
  assign sdata = dat_sync[1];
  assign fall  = sclk_prev & ~sclk;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      sclk_prev <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_data};
      sclk_prev <= sclk;
    end
  end

  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          tout;

  assign tout = (state != IDLE) && !fall && (tcnt == TLIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else if (fall) begin
      tcnt <= '0;
      case (state)
        IDLE:   if (!sdata) begin
                  state   <= DATA;
                  bit_idx <= '0;
                end
        DATA:   begin
                  shreg   <= {sdata, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= PARITY;
                end
        PARITY: begin
                  par_bit <= sdata;
                  state   <= STOP;
                end
        default: state <= IDLE;
      endcase
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else if (tout) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame outcome is decided on the STOP-bit falling edge itself
  logic stop_ev, par_ok, push, perr_set, ferr_set;
  assign stop_ev  = fall && (state == STOP);
  assign par_ok   = ^{shreg, par_bit};
  assign push     = stop_ev && sdata && par_ok;
  assign perr_set = stop_ev && sdata && !par_ok;
  assign ferr_set = (stop_ev && !sdata) || tout;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, wr, ovf_set;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop     = bus.renable && (bus.raddr == DATA_ADDR) && !empty;
  // When full, a simultaneous pop frees the slot the push lands in
  assign wr      = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clock) begin
    if (wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic perr, ovf, ferr, clr;
  assign clr = bus.wenable && (bus.waddr == BASE_ADDR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perr <= 1'b0;
      ovf  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      perr <= perr_set | (perr & ~(clr & bus.wdata[2]));
      ovf  <= ovf_set  | (ovf  & ~(clr & bus.wdata[3]));
      ferr <= ferr_set | (ferr & ~(clr & bus.wdata[4]));
    end
  end

  logic [4:0]  cnt5;
  logic [15:0] status;
  logic        unused_wdata;
  assign cnt5         = 5'(count);
  assign status       = {3'b000, cnt5, 3'b000, ferr, ovf, perr, full, !empty};
  assign unused_wdata = ^{bus.wdata[15:5], bus.wdata[1:0]};

  always_comb begin
    bus.rdata = 16'h0000;
    if (bus.raddr == BASE_ADDR)
      bus.rdata = status;
    else if (bus.raddr == DATA_ADDR && !empty)
      bus.rdata = {8'h00, mem[rptr]};
  end

  assign bus.rx_ready = !empty;
endmodule

// File: tb/tb_ps2_keyboard_io.sv
// Randomised frame/pop/clear stimulus checked against a queue-and-flags model of the keyboard port.
module tb_ps2_keyboard_io;
  localparam logic [15:0] BASE  = 16'hFF10;
  localparam logic [15:0] DADDR = 16'hFF11;
  localparam int DEPTH = 8;
  localparam int TOUT  = 300;

  logic clock = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  ps2_keyboard_io_if bus();

  ps2_keyboard_io #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus.slave)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  byte unsigned q[$];
  bit m_perr, m_ovf, m_ferr;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_status();
    int c = q.size();
    return {3'b000, 5'(c), 3'b000, m_ferr, m_ovf, m_perr, c == DEPTH, c != 0};
  endfunction

  task automatic check_status(input string tag);
    logic [15:0] v;
    @(negedge clock);
    bus.raddr = BASE;
    #1 v = bus.rdata;
    chk(tag, v, exp_status());
    chk({tag, "_rdy"}, {15'd0, bus.rx_ready}, {15'd0, q.size() != 0});
  endtask

  task automatic model_pop(input string tag, input logic [15:0] got);
    chk(tag, got, (q.size() != 0) ? {8'h00, q[0]} : 16'h0000);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] v;
    @(negedge clock);
    bus.raddr   = DADDR;
    bus.renable = 1'b1;
    #1 v = bus.rdata;
    model_pop(tag, v);
    @(negedge clock);
    bus.renable = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    bus.waddr = a; bus.wdata = d; bus.wenable = 1'b1;
    @(negedge clock);
    bus.wenable = 1'b0;
    if (a == BASE) begin
      if (d[2]) m_perr = 1'b0;
      if (d[3]) m_ovf  = 1'b0;
      if (d[4]) m_ferr = 1'b0;
    end
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    repeat (4) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  // pop_at_stop lines a DATA pop up with the cycle the STOP edge is seen past the synchroniser
  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit pop_at_stop);
    bit p;
    logic [15:0] v;
    p = (~^d) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_data = ~bad_stop;
    repeat (4) @(negedge clock);
    ps2_clk = 1'b0;
    if (pop_at_stop) begin
      repeat (2) @(negedge clock);
      bus.raddr   = DADDR;
      bus.renable = 1'b1;
      #1 v = bus.rdata;
      model_pop("stop_pop", v);
      @(negedge clock);
      bus.renable = 1'b0;
      @(negedge clock);
    end else begin
      repeat (4) @(negedge clock);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clock);
    if (bad_stop)              m_ferr = 1'b1;
    else if (bad_par)          m_perr = 1'b1;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else                       q.push_back(d);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    bus.raddr = '0; bus.renable = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wenable = 1'b0;
    repeat (3) @(negedge clock);
    check_status("rst_status");
    pop_chk("rst_data");
    reset = 1'b1;

    @(negedge clock);
    bus.raddr = 16'h1234;
    #1 chk("unmapped", bus.rdata, 16'h0000);

    send(8'h1C, 0, 0, 0);
    check_status("t1_status");
    pop_chk("t1_pop");
    check_status("t1_after");

    send(8'hF0, 1, 0, 0);
    check_status("t2_perr");
    wr(BASE, 16'h0004);
    check_status("t2_clr");

    for (int i = 1; i <= 9; i++) send(8'(i), 0, 0, 0);
    check_status("t3_full");
    wr(DADDR, 16'hFFFF);
    check_status("t3_wr_data");
    for (int i = 0; i < 8; i++) pop_chk("t3_pop");
    wr(BASE, 16'h0008);
    check_status("t3_clr");

    for (int i = 0; i < 8; i++) send(8'($urandom), 0, 0, 0);
    send(8'hA7, 0, 0, 1);
    check_status("t4_status");
    for (int i = 0; i < 8; i++) pop_chk("t4_pop");

    send_partial(3);
    repeat (TOUT + 10) @(negedge clock);
    m_ferr = 1'b1;
    check_status("t5_ferr");
    send(8'h5A, 0, 0, 0);
    check_status("t5_status");
    pop_chk("t5_pop");
    wr(BASE, 16'h001C);

    send(8'h11, 0, 0, 0);
    send(8'h22, 1, 0, 0);
    send(8'h33, 0, 0, 0);
    send_partial(4);
    @(negedge clock);
    bus.raddr = BASE;
    #2 reset = 1'b0;
    q.delete(); m_perr = 0; m_ovf = 0; m_ferr = 0;
    #1 chk("t6_rst_status", bus.rdata, exp_status());
    chk("t6_rst_rdy", {15'd0, bus.rx_ready}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    send(8'h29, 0, 0, 0);
    check_status("t6_status");
    pop_chk("t6_pop");

    for (int n = 0; n < 60; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 6) begin
        int e = $urandom_range(0, 9);
        send(8'($urandom), e == 0, e == 1, ($urandom_range(0, 3) == 0));
      end else if (r < 8) begin
        pop_chk("rnd_pop");
      end else if (r == 8) begin
        wr(BASE, 16'($urandom));
      end
      check_status("rnd_status");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
